// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and default operand width for serial_adder
package serial_adder_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: 1-bit gate-level full adder cell, s = a^b^cin, c = majority(a, b, cin)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);
    logic p, ab, bc, ca;
    xor g_p  (p, a, b);
    xor g_s  (s, p, cin);
    and g_ab (ab, a, b);
    and g_bc (bc, b, cin);
    and g_ca (ca, cin, a);
    or  g_c  (c, ab, bc, ca);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder built from one full-adder cell and a carry FF,
// with a start/busy/done handshake and registered sum/cout held between completions.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] opa_q, opb_q, sum_q;
    logic [WIDTH-2:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q, busy_q, done_q, cout_q;
    logic             fa_s, fa_c;

    full_adder u_fa (.a(opa_q[0]), .b(opb_q[0]), .cin(carry_q), .s(fa_s), .c(fa_c));

    // res_q keeps only the upper WIDTH-1 result bits; the final bit arrives on the DONE edge
    assign res_d = {fa_s, res_q};

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= b;
                        carry_q <= cin;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    res_q   <= res_d[WIDTH-1:1];
                    carry_q <= fa_c;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        sum_q   <= res_d;
                        cout_q  <= fa_c;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed table, multi-cycle corner sequences and a randomized
// back-to-back sweep checked against plain a+b+cin arithmetic.
module tb_serial_adder;
    localparam int W = 4;

    logic         clk, rst, start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string        nm;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
    } op_t;

    vec_t tbl[6];
    op_t  pend[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input logic [W-1:0] es, input logic ec);
        logic [W-1:0] prev_s;
        logic         prev_c;
        int           lat, busy_cnt, held;
        prev_s = sum;
        prev_c = cout;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        lat = 0; busy_cnt = 0; held = 1;
        while (!done && lat < 3 * W) begin
            if (busy) busy_cnt++;
            if (sum !== prev_s || cout !== prev_c) held = 0;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, " latency"}, lat, W);
        chk({nm, " busy cycles"}, busy_cnt, W);
        chk({nm, " held"}, held, 1);
        chk({nm, " sum"}, sum, es);
        chk({nm, " cout"}, cout, ec);
        @(posedge clk);
        #1;
        chk({nm, " done single"}, done, 0);
    endtask

    initial begin
        logic [W-1:0] prev_s;
        logic [W:0]   ref_v;
        op_t          o;
        int           dones, held, cyc;
        logic         timed_out;

        tbl[0] = '{"5+3",       4'd5,  4'd3,  1'b0, 4'd8,  1'b0};
        tbl[1] = '{"15+1",      4'd15, 4'd1,  1'b0, 4'd0,  1'b1};
        tbl[2] = '{"15+15+1",   4'd15, 4'd15, 1'b1, 4'd15, 1'b1};
        tbl[3] = '{"9-4",       4'd9,  4'd11, 1'b1, 4'd5,  1'b1};
        tbl[4] = '{"4-9",       4'd4,  4'd6,  1'b1, 4'd11, 1'b0};
        tbl[5] = '{"0+0",       4'd0,  4'd0,  1'b0, 4'd0,  1'b0};

        rst = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset sum", sum, 0);
        chk("reset cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            do_op(tbl[i].nm, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co);
        do_op("9+7 after zero", 4'd9, 4'd7, 1'b0, 4'd0, 1'b1);

        // start pulsed during RUN must be ignored
        prev_s = sum;
        @(negedge clk);
        a = 4'd2; b = 4'd2; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'd1; b = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0; held = 1;
        for (int k = 0; k < 2 * W + 4; k++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
            if (dones == 0 && sum !== prev_s) held = 0;
        end
        chk("ignore done count", dones, 1);
        chk("ignore held", held, 1);
        chk("ignore sum", sum, 4);
        chk("ignore cout", cout, 0);

        // asynchronous reset two cycles into a RUN
        @(negedge clk);
        a = 4'd5; b = 4'd6; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort sum", sum, 0);
        chk("abort cout", cout, 0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 2 * W; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        chk("abort no done", dones, 0);
        do_op("7+7", 4'd7, 4'd7, 1'b0, 4'd14, 1'b0);

        // start held high: back-to-back randomized sweep
        @(negedge clk);
        o.a = W'($urandom); o.b = W'($urandom); o.cin = 1'($urandom);
        a = o.a; b = o.b; cin = o.cin; start = 1'b1;
        pend.push_back(o);
        timed_out = 1'b0;
        for (int n = 0; n < 200 && !timed_out; n++) begin
            cyc = 0;
            do begin
                @(posedge clk);
                #1;
                cyc++;
            end while (!done && cyc < 4 * W);
            if (!done) begin
                chk("sweep timeout", 0, 1);
                timed_out = 1'b1;
            end else begin
                o = pend.pop_front();
                ref_v = {1'b0, o.a} + {1'b0, o.b} + {{W{1'b0}}, o.cin};
                chk($sformatf("sweep %0d sum", n), sum, ref_v[W-1:0]);
                chk($sformatf("sweep %0d cout", n), cout, ref_v[W]);
                if (n > 0) chk($sformatf("sweep %0d interval", n), cyc, W + 1);
                o.a = W'($urandom); o.b = W'($urandom); o.cin = 1'($urandom);
                a = o.a; b = o.b; cin = o.cin;
                pend.push_back(o);
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (2 * W + 2) @(posedge clk);
        #1;
        chk("sweep end idle busy", busy, 0);
        chk("sweep end idle done", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
